fir_tap_sequencer: RTL and testbench
====================================

Name: fir_tap_sequencer

Overview:
Control block that time-multiplexes one shared multi-cycle Booth multiply-accumulate unit across all FIR taps. It accepts input samples on a ready/valid handshake and drives the write/read addressing of a circular sample buffer and the coefficient ROM. For each sample it issues one MAC operation per tap, then publishes the accumulated result with a one-cycle w_valid pulse. It sits between the sample source and the fir datapath (sample buffer, coefficient ROM, Booth MAC).

Parameters:
WL, 14, input sample word length (buffer data width, informational)
MAC_WL, 20, accumulator/result word length
TAP_NUM, 37, number of taps = circular buffer depth = coefficient count
ADDR_W, 6, address width; must satisfy 2**ADDR_W >= TAP_NUM

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  source presents a sample on the datapath data_in
r_ready  out  1  sequencer can accept a sample
buf_we  out  1  sample buffer write enable
buf_wzero  out  1  buffer write data = 0 (flush) instead of data_in
buf_waddr  out  ADDR_W  sample buffer write address
buf_raddr  out  ADDR_W  sample buffer read address for the current tap
coef_addr  out  ADDR_W  coefficient ROM address = current tap index
mac_start  out  1  one-cycle pulse: MAC begins the product for the current tap
mac_clr  out  1  with mac_start: accumulator loads the product instead of adding
mac_done  in  1  MAC finished the current tap; accumulator updated
acc_in  in  MAC_WL  accumulator value from the MAC, signed
data_out  out  MAC_WL  filter result, signed, held until the next result
w_valid  out  1  one-cycle pulse: data_out is new
busy  out  1  high in every state except IDLE

Behaviour:
- States: INIT, IDLE, ISSUE, WAIT, DONE. Reset -> INIT with wr_ptr=0, k=0, data_out=0, w_valid=0, mac_start=0, r_ready=0.
- INIT: buf_we=1, buf_wzero=1, buf_waddr=k; k advances 0..TAP_NUM-1, one entry per cycle; after entry TAP_NUM-1 -> IDLE, k=0. Duration is exactly TAP_NUM cycles.
- IDLE: r_ready=1. Accept happens when r_ready & in_valid. On accept (combinational): buf_we=1, buf_wzero=0, buf_waddr=wr_ptr.
  - Registered on accept: newest<=wr_ptr; wr_ptr<=(wr_ptr==TAP_NUM-1)?0:wr_ptr+1; k<=0; -> ISSUE.
- ISSUE (one cycle): mac_start=1; mac_clr=(k==0); coef_addr=k; buf_raddr=(newest-k) mod TAP_NUM, computed by wrap-around subtraction, never a raw binary wrap. -> WAIT.
- WAIT: buf_raddr and coef_addr are held stable.
  - On mac_done with k==TAP_NUM-1 -> DONE.
  - On mac_done otherwise -> k<=k+1, ISSUE.
  - MAC latency L>=1 cycle, arbitrary and variable per tap. There is no timeout.
- DONE (one cycle): data_out<=acc_in; w_valid<=1 registered, so it is high during the cycle after DONE; -> IDLE.
  - Throughput: 1 + TAP_NUM*(1+L) + 1 cycles per sample. r_ready is low from the accept cycle+1 until IDLE is re-entered.
- r_ready in the same cycle as w_valid is allowed (IDLE re-entered).
- mac_done outside WAIT is ignored. This includes mac_done in the same cycle as mac_start.
- in_valid outside IDLE is ignored; the source must hold the sample until accepted.
- rst at any point, including mid-WAIT: next state INIT, the partial result is discarded, w_valid=0, data_out=0, wr_ptr=0, and the buffer is re-flushed.
- Arithmetic: no arithmetic on sample data in this block. Saturation/rounding belongs to the MAC. data_out is a straight register copy of acc_in.

Decomposition:
- Shared package fir_pkg: state enum (INIT, IDLE, ISSUE, WAIT, DONE), WL/MAC_WL/TAP_NUM/ADDR_W defaults, and a modular-decrement function for tap addressing.
- One sub-module is natural: fir_ring_ptr, a mod-TAP_NUM counter with inc/clear and an offset-read output (newest-k). It is used for both wr_ptr and read-address generation.

Test Plan:
- Reset: rst high 2 cycles, then low -> buf_we=1, buf_wzero=1, buf_waddr=0..36 over 37 consecutive cycles, r_ready=0 throughout; r_ready=1 on cycle 38.
- First sample: in_valid=1 in IDLE with MAC model L=1 -> buf_waddr=0; raddr sequence 0,36,35,...,1 with coef_addr 0..36 and mac_clr only on tap 0; w_valid 1 cycle, 1+37*2+1=76 cycles after accept.
- Wrap: feed 38 samples back-to-back -> sample 37 writes addr 36, sample 38 writes addr 0 with raddr sequence 0,36,...,1; no address ever equals 37..63.
- Variable latency: MAC model returns mac_done after 1..8 random cycles, plus spurious mac_done pulses in IDLE/ISSUE -> exactly 37 mac_start per sample, exactly one w_valid per sample, and data_out equal to the model accumulator (e.g. impulse 1 with coefficients c[k] gives the outputs c[0..36] over successive samples).
- Reset mid-operation: assert rst during WAIT at k=20 -> no w_valid; data_out=0; INIT flush repeats (37 cycles); next sample written at addr 0.
- Backpressure: in_valid held high continuously -> a sample is accepted only in IDLE cycles, and no sample is accepted during INIT/ISSUE/WAIT/DONE.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR tap sequencer: state encoding, default
// sizes and the wrap-around subtraction used for circular-buffer addressing.
package fir_pkg;

  localparam int WL_DEFAULT      = 14;
  localparam int MAC_WL_DEFAULT  = 20;
  localparam int TAP_NUM_DEFAULT = 37;
  localparam int ADDR_W_DEFAULT  = 6;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // (a - b) mod n for a, b already in 0..n-1; never relies on a binary wrap.
  function automatic int unsigned mod_dec(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned n);
    if (a >= b) return a - b;
    else        return a + n - b;
  endfunction

endpackage

// File: rtl/fir_ring_ptr.sv
// Mod-TAP_NUM write pointer for the circular sample buffer. Also remembers the
// slot of the newest sample and produces the tap read address newest - offset.
module fir_ring_ptr
  import fir_pkg::*;
#(
  parameter int TAP_NUM = TAP_NUM_DEFAULT,
  parameter int ADDR_W  = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] value,
  output logic [ADDR_W-1:0] back
);

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] newest;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr    <= '0;
      newest <= '0;
    end else if (inc) begin
      newest <= ptr;
      ptr    <= (ptr == ADDR_W'(TAP_NUM - 1)) ? '0 : ptr + 1'b1;
    end
  end

  assign value = ptr;
  assign back  = ADDR_W'(mod_dec(32'(newest), 32'(offset), TAP_NUM));

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexes one shared multi-cycle MAC across all FIR taps: flushes the
// sample buffer, accepts samples, issues one MAC per tap and publishes results.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int WL      = WL_DEFAULT,
  parameter int MAC_WL  = MAC_WL_DEFAULT,
  parameter int TAP_NUM = TAP_NUM_DEFAULT,
  parameter int ADDR_W  = ADDR_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     r_ready,
  output logic                     buf_we,
  output logic                     buf_wzero,
  output logic [ADDR_W-1:0]        buf_waddr,
  output logic [ADDR_W-1:0]        buf_raddr,
  output logic [ADDR_W-1:0]        coef_addr,
  output logic                     mac_start,
  output logic                     mac_clr,
  input  logic                     mac_done,
  input  logic signed [MAC_WL-1:0] acc_in,
  output logic signed [MAC_WL-1:0] data_out,
  output logic                     w_valid,
  output logic                     busy
);

  if ((2 ** ADDR_W) < TAP_NUM || WL < 1) begin : g_bad_params
    $error("fir_tap_sequencer: ADDR_W too small for TAP_NUM or WL invalid");
  end

  // Handshake: a sample transfers on a rising clk edge where in_valid and
  // r_ready are both high; the source holds the sample until that edge.
  state_t            state;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic              accept;
  logic              last_tap;

  assign accept   = (state == IDLE) && in_valid;
  assign last_tap = (k == ADDR_W'(TAP_NUM - 1));

  fir_ring_ptr #(
    .TAP_NUM (TAP_NUM),
    .ADDR_W  (ADDR_W)
  ) u_ring (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == INIT),
    .inc    (accept),
    .offset (k),
    .value  (wr_ptr),
    .back   (rd_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      k        <= '0;
      data_out <= '0;
      w_valid  <= 1'b0;
    end else begin
      w_valid <= 1'b0;
      case (state)
        INIT: begin
          if (last_tap) begin
            k     <= '0;
            state <= IDLE;
          end else begin
            k <= k + 1'b1;
          end
        end
        IDLE: begin
          if (in_valid) begin
            k     <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        // mac_done only counts here, so early or stray pulses are ignored.
        WAIT: begin
          if (mac_done) begin
            if (last_tap) begin
              state <= DONE;
            end else begin
              k     <= k + 1'b1;
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          data_out <= acc_in;
          w_valid  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

  assign r_ready   = (state == IDLE);
  assign busy      = (state != IDLE);
  assign buf_we    = (state == INIT) || accept;
  assign buf_wzero = (state == INIT);
  assign buf_waddr = (state == INIT) ? k : wr_ptr;
  assign buf_raddr = rd_addr;
  assign coef_addr = k;
  assign mac_start = (state == ISSUE);
  assign mac_clr   = (state == ISSUE) && (k == '0);

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: a sample-buffer and Booth-MAC stand-in driven by
// the DUT addresses, checked against a direct FIR sum over accepted samples.
module tb_fir_tap_sequencer;

  localparam int TAPS = 37;
  localparam int MW   = 20;
  localparam int AW   = 6;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0;
  logic                 mac_done = 1'b0;
  logic signed [MW-1:0] acc_in   = '0;
  logic signed [13:0]   data_in  = '0;
  logic                 r_ready, buf_we, buf_wzero, mac_start, mac_clr, w_valid, busy;
  logic [AW-1:0]        buf_waddr, buf_raddr, coef_addr;
  logic signed [MW-1:0] data_out;

  fir_tap_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .r_ready   (r_ready),
    .buf_we    (buf_we),
    .buf_wzero (buf_wzero),
    .buf_waddr (buf_waddr),
    .buf_raddr (buf_raddr),
    .coef_addr (coef_addr),
    .mac_start (mac_start),
    .mac_clr   (mac_clr),
    .mac_done  (mac_done),
    .acc_in    (acc_in),
    .data_out  (data_out),
    .w_valid   (w_valid),
    .busy      (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int coef(input int idx);
    return 3 * idx - 50;
  endfunction

  // datapath stand-in: sample buffer and MAC with programmable latency
  int lat_min = 1;
  int lat_max = 1;
  bit spurious_en = 1'b0;
  int mem [64];
  int acc_model = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (buf_we === 1'b1) mem[buf_waddr] = buf_wzero ? 0 : int'(data_in);
    end
  end

  initial begin
    int rem;
    int prod;
    bit clr;
    bit pend;
    rem = 0; prod = 0; clr = 1'b0; pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mac_done = 1'b0;
      if (rst) begin
        pend = 1'b0;
        rem  = 0;
      end else if (pend) begin
        rem--;
        if (rem == 0) begin
          acc_model = clr ? prod : acc_model + prod;
          acc_in    = acc_model[MW-1:0];
          mac_done  = 1'b1;
          pend      = 1'b0;
        end
      end else if (mac_start) begin
        pend = 1'b1;
        rem  = $urandom_range(lat_max, lat_min);
        prod = coef(int'(coef_addr)) * mem[buf_raddr];
        clr  = mac_clr;
        if (spurious_en && $urandom_range(1, 0) == 1) mac_done = 1'b1;
      end else if (spurious_en && $urandom_range(3, 0) == 0) begin
        mac_done = 1'b1;
      end
    end
  end

  // scoreboard: reference FIR over the accepted sample history
  logic signed [MW-1:0] exp_q [$];
  logic signed [MW-1:0] last_exp = '0;
  int hist [$];
  int cyc = 0, exp_wr = 0, exp_newest = 0, exp_tap = 0, init_cnt = 0, accept_cyc = 0;
  bit in_init = 1'b1, in_sample = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_init = 1'b1; init_cnt = 0; in_sample = 1'b0;
        exp_wr = 0; exp_tap = 0; last_exp = '0;
        hist.delete(); exp_q.delete();
      end else if (in_init) begin
        if (init_cnt == 0) begin
          check("reset_w_valid", w_valid, 0);
          check("reset_data_out", data_out, 0);
          check("reset_mac_start", mac_start, 0);
        end
        check("init_flush", {r_ready, busy, buf_we, buf_wzero}, 4'b0111);
        check("init_waddr", buf_waddr, init_cnt);
        init_cnt++;
        if (init_cnt == TAPS) in_init = 1'b0;
      end else begin
        bit acc_now;
        int y;
        if (w_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_w_valid", 1, 0);
          end else begin
            last_exp = exp_q.pop_front();
            check("taps_per_sample", exp_tap, TAPS);
            if (lat_max == 1) check("result_latency", cyc - accept_cyc, 76);
          end
          in_sample = 1'b0;
        end
        check("data_out", data_out, last_exp);
        check("ready_busy", {r_ready, busy}, in_sample ? 1 : 2);
        acc_now = !in_sample && in_valid;
        check("buf_we", {buf_we, buf_wzero}, acc_now ? 2 : 0);
        if (acc_now) begin
          check("accept_waddr", buf_waddr, exp_wr);
          exp_newest = exp_wr;
          exp_wr     = (exp_wr + 1) % TAPS;
          exp_tap    = 0;
          in_sample  = 1'b1;
          accept_cyc = cyc;
          hist.push_front(int'(data_in));
          if (hist.size() > TAPS) void'(hist.pop_back());
          y = 0;
          foreach (hist[i]) y += coef(i) * hist[i];
          exp_q.push_back(y[MW-1:0]);
        end else if (mac_start) begin
          check("start_in_sample", in_sample, 1);
          check("coef_addr", coef_addr, exp_tap);
          check("buf_raddr", buf_raddr, (exp_newest - exp_tap + TAPS) % TAPS);
          check("mac_clr", mac_clr, exp_tap == 0);
          exp_tap++;
        end
      end
    end
  end

  // driver tasks
  bit keep_valid = 1'b0;

  task automatic send(input int d);
    int n;
    @(posedge clk);
    #1;
    data_in  = d[13:0];
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!r_ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_result(output int v);
    int n;
    n = 0;
    @(negedge clk);
    while (!w_valid && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) check("result_timeout", 1, 0);
    v = int'(data_out);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!r_ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) check("idle_timeout", 1, 0);
  endtask

  initial begin
    int v;
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // impulse through all taps plus one wrap of the circular buffer, latency 1
    for (int s = 0; s < 38; s++) begin
      send(s == 0 ? 1 : 0);
      wait_result(v);
      check("impulse_out", v, (s < 37) ? (3 * s - 50) : 0);
    end
    check("model_wrap_ptr", exp_wr, 1);

    // back-to-back samples, random MAC latency, stray mac_done pulses
    lat_min = 1; lat_max = 8; spurious_en = 1'b1; keep_valid = 1'b1;
    for (int s = 0; s < 12; s++) send($urandom_range(400, 0) - 200);
    keep_valid = 1'b0;
    in_valid   = 1'b0;
    wait_idle();
    spurious_en = 1'b0;

    // reset in the middle of a sample, in WAIT at tap 20
    lat_min = 3; lat_max = 5;
    send(77);
    n = 0;
    while (exp_tap < 21 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) check("tap20_timeout", 1, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lat_min = 1; lat_max = 1;
    wait_idle();
    check("post_reset_data_out", data_out, 0);
    send(5);
    wait_result(v);
    check("post_reset_impulse", v, -250);
    check("post_reset_newest", exp_newest, 0);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
